// File: rtl/console_arbiter_pkg.sv
// Shared constants and RX handshake state encoding for the console arbiter.
package console_arbiter_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DATA_W        = 8;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/console_fifo.sv
// Registered output FIFO: head byte and flags are flops, so a push is visible one cycle later.
module console_fifo
    import console_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              valid_o,
    output logic              full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     rd_next;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & valid_q;
    assign rd_next = rd_ptr_q + AW'(1);

    // Next head is the pushed byte when it lands at the read position, otherwise the following entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        head_d   = head_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end
        if (push_ok && ((count_q == CW'(0)) || ((count_q == CW'(1)) && pop_ok))) begin
            head_d = push_data_i;
        end else if (pop_ok) begin
            head_d = mem_q[rd_next];
        end
        valid_d = (count_d != CW'(0));
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/console_arbiter.sv
// Two-requester console output arbiter with a 4-phase console input capture register.
module console_arbiter
    import console_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_valid_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    output logic              wr0_ready_o,
    input  logic              wr1_valid_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic              wr1_ready_o,
    output logic [DATA_W-1:0] console_out_o,
    output logic              console_out_valid_o,
    input  logic              console_out_ready_i,
    input  logic [DATA_W-1:0] console_in_i,
    input  logic              console_in_valid_i,
    output logic              console_in_ack_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_full_o,
    input  logic              rx_rd_i
);

    logic              fifo_full;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop;
    logic              grant0, grant1;
    logic              last_q, last_d;

    // On a tie the requester that did not get the previous accepted push wins.
    assign grant0 = wr0_valid_i & (~wr1_valid_i | last_q);
    assign grant1 = wr1_valid_i & (~wr0_valid_i | ~last_q);

    assign wr0_ready_o = rst_n & grant0 & ~fifo_full;
    assign wr1_ready_o = rst_n & grant1 & ~fifo_full;

    assign fifo_push = (wr0_valid_i & wr0_ready_o) | (wr1_valid_i & wr1_ready_o);
    assign fifo_data = wr1_ready_o ? wr1_data_i : wr0_data_i;
    assign fifo_pop  = console_out_valid_o & console_out_ready_i;
    assign last_d    = fifo_push ? wr1_ready_o : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    console_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_data),
        .pop_i       (fifo_pop),
        .head_o      (console_out_o),
        .valid_o     (console_out_valid_o),
        .full_o      (fifo_full)
    );

    rx_state_e         state_q, state_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_full_q, rx_full_d;
    logic              ack_q, ack_d;

    // Capture only into an empty holding register; a full one back-pressures the console.
    always_comb begin
        state_d   = state_q;
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        ack_d     = 1'b0;
        if (rx_rd_i && rx_full_q) begin
            rx_full_d = 1'b0;
        end
        case (state_q)
            RX_IDLE: begin
                if (console_in_valid_i && !rx_full_q) begin
                    state_d   = RX_ACK;
                    rx_data_d = console_in_i;
                    rx_full_d = 1'b1;
                end
            end
            RX_ACK: begin
                if (!console_in_valid_i) begin
                    state_d = RX_IDLE;
                end
            end
        endcase
        ack_d = (state_d == RX_ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
            ack_q     <= ack_d;
        end
    end

    assign console_in_ack_o = ack_q;
    assign rx_data_o        = rx_data_q;
    assign rx_full_o        = rx_full_q;

endmodule

// File: tb/tb_console_arbiter.sv
// Directed bench for console_arbiter: queue-based reference model plus hand-computed scenario checks.
module tb_console_arbiter;
    import console_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       wr0_valid, wr1_valid, wr0_ready, wr1_ready;
    logic [7:0] wr0_data, wr1_data;
    logic [7:0] cout;
    logic       cout_valid, cout_ready;
    logic [7:0] cin;
    logic       cin_valid, cin_ack;
    logic [7:0] rx_data;
    logic       rx_full, rx_rd;

    console_arbiter #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr0_valid_i         (wr0_valid),
        .wr0_data_i          (wr0_data),
        .wr0_ready_o         (wr0_ready),
        .wr1_valid_i         (wr1_valid),
        .wr1_data_i          (wr1_data),
        .wr1_ready_o         (wr1_ready),
        .console_out_o       (cout),
        .console_out_valid_o (cout_valid),
        .console_out_ready_i (cout_ready),
        .console_in_i        (cin),
        .console_in_valid_i  (cin_valid),
        .console_in_ack_o    (cin_ack),
        .rx_data_o           (rx_data),
        .rx_full_o           (rx_full),
        .rx_rd_i             (rx_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte queue, last-served id, RX holding register and handshake flag.
    bit [7:0] mq[$];
    bit       m_last;
    bit       m_full;
    bit       m_ack;
    bit [7:0] m_data;
    logic [7:0] acc[$];
    logic [7:0] pops[$];

    always @(negedge clk) begin
        bit g0, g1, r0, r1, old_full;
        if (!rst_n) begin
            mq.delete();
            m_last = 1'b1;
            m_full = 1'b0;
            m_ack  = 1'b0;
            m_data = 8'h00;
        end
        g0 = wr0_valid && (!wr1_valid || m_last);
        g1 = wr1_valid && (!wr0_valid || !m_last);
        r0 = rst_n && g0 && (mq.size() < DEPTH);
        r1 = rst_n && g1 && (mq.size() < DEPTH);
        chk("out_valid", 32'(cout_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", 32'(cout), 32'(mq[0]));
        chk("wr0_ready", 32'(wr0_ready), 32'(r0));
        chk("wr1_ready", 32'(wr1_ready), 32'(r1));
        chk("rx_full", 32'(rx_full), 32'(m_full));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("in_ack", 32'(cin_ack), 32'(m_ack));
        if (rst_n) begin
            if (wr0_valid && wr0_ready) acc.push_back(wr0_data);
            if (wr1_valid && wr1_ready) acc.push_back(wr1_data);
            if (cout_ready && mq.size() != 0) begin
                pops.push_back(cout);
                void'(mq.pop_front());
            end
            if (r0) begin
                mq.push_back(wr0_data);
                m_last = 1'b0;
            end else if (r1) begin
                mq.push_back(wr1_data);
                m_last = 1'b1;
            end
            old_full = m_full;
            if (m_ack) begin
                if (!cin_valid) m_ack = 1'b0;
            end else if (cin_valid && !old_full) begin
                m_ack  = 1'b1;
                m_full = 1'b1;
                m_data = cin;
            end
            if (rx_rd && old_full) m_full = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr0_valid = 1'b1; wr0_data = 8'h00;
        wr1_valid = 1'b0; wr1_data = 8'h00;
        cout_ready = 1'b0; cin = 8'h00; cin_valid = 1'b0; rx_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(cout_valid), 32'h0);
        chk("rst_out", 32'(cout), 32'h0);
        chk("rst_wr0_ready", 32'(wr0_ready), 32'h0);
        chk("rst_rx_full", 32'(rx_full), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_ack", 32'(cin_ack), 32'h0);
        wr0_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Tie between requesters alternates, requester 0 first after reset.
        acc.delete(); pops.delete();
        cout_ready = 1'b1;
        wr0_valid = 1'b1; wr0_data = 8'h30;
        wr1_valid = 1'b1; wr1_data = 8'h31;
        repeat (4) cyc();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        repeat (3) cyc();
        chk("tie_acc_count", 32'(acc.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < acc.size()) chk("tie_acc_order", 32'(acc[i]), (i % 2 == 1) ? 32'h31 : 32'h30);
        chk("tie_pop_count", 32'(pops.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < pops.size()) chk("tie_pop_order", 32'(pops[i]), (i % 2 == 1) ? 32'h31 : 32'h30);

        // Single requester, one-cycle latency to the output.
        wr0_valid = 1'b1; wr0_data = 8'h41;
        #1 chk("lat_valid_before", 32'(cout_valid), 32'h0);
        cyc();
        chk("lat_valid_first", 32'(cout_valid), 32'h1);
        chk("lat_out_41", 32'(cout), 32'h41);
        wr0_data = 8'h42;
        cyc();
        wr0_valid = 1'b0;
        chk("lat_out_42", 32'(cout), 32'h42);
        chk("lat_valid_42", 32'(cout_valid), 32'h1);
        cyc();
        chk("lat_drained", 32'(cout_valid), 32'h0);

        // Fill to DEPTH with the sink stalled; no bypass on the pop cycle.
        acc.delete(); pops.delete();
        cout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr0_data = 8'(8'h50 + i); wr0_valid = 1'b1;
            #1 chk("fill_ready", 32'(wr0_ready), 32'h1);
            cyc();
        end
        wr0_data = 8'h54;
        repeat (3) begin
            #1 chk("full_ready_low", 32'(wr0_ready), 32'h0);
            chk("full_head_stable", 32'(cout), 32'h50);
            chk("full_valid_stable", 32'(cout_valid), 32'h1);
            cyc();
        end
        cout_ready = 1'b1;
        #1 chk("full_no_bypass", 32'(wr0_ready), 32'h0);
        cyc();
        #1 chk("after_pop_ready", 32'(wr0_ready), 32'h1);
        chk("after_pop_head", 32'(cout), 32'h51);
        cyc();
        wr0_valid = 1'b0;
        repeat (6) cyc();
        chk("full_acc_count", 32'(acc.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < acc.size()) chk("full_acc_order", 32'(acc[i]), 32'h50 + 32'(i));
        chk("full_pop_count", 32'(pops.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < pops.size()) chk("full_pop_order", 32'(pops[i]), 32'h50 + 32'(i));
        chk("full_drained", 32'(cout_valid), 32'h0);

        // Console input handshake and back-pressure while unread.
        cin = 8'h5A; cin_valid = 1'b1;
        cyc();
        chk("rx_ack_5a", 32'(cin_ack), 32'h1);
        chk("rx_full_5a", 32'(rx_full), 32'h1);
        chk("rx_data_5a", 32'(rx_data), 32'h5A);
        cyc();
        chk("rx_ack_hold", 32'(cin_ack), 32'h1);
        cin_valid = 1'b0;
        cyc();
        chk("rx_ack_drop", 32'(cin_ack), 32'h0);
        chk("rx_full_kept", 32'(rx_full), 32'h1);
        cin = 8'h5B; cin_valid = 1'b1;
        repeat (3) begin
            cyc();
            chk("rx_withheld_ack", 32'(cin_ack), 32'h0);
            chk("rx_withheld_data", 32'(rx_data), 32'h5A);
        end
        rx_rd = 1'b1;
        cyc();
        rx_rd = 1'b0;
        chk("rx_rd_clears", 32'(rx_full), 32'h0);
        chk("rx_rd_ack", 32'(cin_ack), 32'h0);
        chk("rx_rd_data_hold", 32'(rx_data), 32'h5A);
        cyc();
        chk("rx_5b_full", 32'(rx_full), 32'h1);
        chk("rx_5b_data", 32'(rx_data), 32'h5B);
        chk("rx_5b_ack", 32'(cin_ack), 32'h1);
        cin_valid = 1'b0;
        cyc();
        chk("rx_5b_ack_drop", 32'(cin_ack), 32'h0);

        // Mid-traffic reset discards queued bytes and the unread RX byte.
        cout_ready = 1'b0;
        wr1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr1_data = 8'(8'h60 + i);
            cyc();
        end
        wr1_valid = 1'b0;
        chk("pre_rst_head", 32'(cout), 32'h60);
        chk("pre_rst_valid", 32'(cout_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(cout_valid), 32'h0);
        chk("async_rst_out", 32'(cout), 32'h0);
        chk("async_rst_rx_full", 32'(rx_full), 32'h0);
        chk("async_rst_rx_data", 32'(rx_data), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        wr0_valid = 1'b1; wr0_data = 8'h77; cout_ready = 1'b1;
        cyc();
        wr0_valid = 1'b0;
        chk("post_rst_valid", 32'(cout_valid), 32'h1);
        chk("post_rst_out", 32'(cout), 32'h77);
        cyc();
        chk("post_rst_drained", 32'(cout_valid), 32'h0);

        // Read strobe with an empty holding register is ignored.
        cin = 8'h33; cin_valid = 1'b1;
        cyc();
        chk("rx33_full", 32'(rx_full), 32'h1);
        chk("rx33_data", 32'(rx_data), 32'h33);
        cin_valid = 1'b0; rx_rd = 1'b1;
        cyc();
        chk("rx33_read", 32'(rx_full), 32'h0);
        cyc();
        rx_rd = 1'b0;
        chk("rx_rd_empty_ignored", 32'(rx_full), 32'h0);
        chk("rx_data_retained", 32'(rx_data), 32'h33);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/console_arbiter.md
CONSOLE_ARBITER -- requirements
Module: console_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of output FIFO entries (power of two, 2..16).
REQ-002 CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 WR0_valid  input  1  requester 0 (processor MMIO) byte offered.
REQ-005 WR0_data  input  8  requester 0 byte.
REQ-006 WR0_ready  output  1  requester 0 byte accepted this cycle when WR0_valid is also high.
REQ-007 WR1_valid  input  1  requester 1 (echo/debug source) byte offered.
REQ-008 WR1_data  input  8  requester 1 byte.
REQ-009 WR1_ready  output  1  requester 1 byte accepted this cycle when WR1_valid is also high.
REQ-010 CONSOLE_OUT  output  8  byte at FIFO head.
REQ-011 CONSOLE_OUT_valid  output  1  FIFO non-empty.
REQ-012 CONSOLE_OUT_ready  input  1  console sink takes the head byte.
REQ-013 CONSOLE_IN  input  8  received console byte.
REQ-014 CONSOLE_IN_valid  input  1  console byte present (4-phase handshake).
REQ-015 CONSOLE_IN_ack  output  1  console byte captured.
REQ-016 RX_data  output  8  captured input byte for the processor.
REQ-017 RX_full  output  1  RX_data holds an unread byte.
REQ-018 RX_rd  input  1  one-cycle processor read strobe; clears RX_full.

Function
REQ-019 Output FIFO push SHALL occur for at most one requester per cycle; pop SHALL occur when CONSOLE_OUT_valid and CONSOLE_OUT_ready are both high.
REQ-020 WRx_ready SHALL be high only for the granted requester and only when the FIFO is not full (no full-with-pop bypass).
REQ-021 Grant: single valid requester wins; both valid -> requester not served by the last accepted push wins; last_served SHALL update only on an accepted push.
REQ-022 A pushed byte SHALL appear on CONSOLE_OUT with CONSOLE_OUT_valid one cycle after acceptance (registered FIFO, no same-cycle pass-through).
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-024 CONSOLE_OUT and CONSOLE_OUT_valid SHALL stay stable while CONSOLE_OUT_valid is high and CONSOLE_OUT_ready is low.
REQ-025 Input FSM states: RX_IDLE, RX_ACK.
REQ-026 RX_IDLE -> RX_ACK when CONSOLE_IN_valid=1 and RX_full=0: CONSOLE_IN latched into RX_data, RX_full set.
REQ-027 RX_IDLE with CONSOLE_IN_valid=1 and RX_full=1 SHALL hold (back-pressure; byte not acknowledged).
REQ-028 In RX_ACK CONSOLE_IN_ack SHALL be 1 (registered); RX_ACK -> RX_IDLE when CONSOLE_IN_valid=0.
REQ-029 RX_rd SHALL clear RX_full the next cycle; RX_rd with RX_full=0 SHALL be ignored; RX_data SHALL hold its value until next capture.
REQ-030 RX_rd in the same cycle as a capture is impossible by REQ-026 gating; RX_rd and capture in consecutive cycles SHALL both take effect.

Reset
REQ-031 On RESET low, asynchronously: FIFO empty, pointers 0, last_served=1 (requester 0 wins first tie), CONSOLE_OUT_valid=0, CONSOLE_OUT=0, WR0_ready=WR1_ready=0, FSM=RX_IDLE, CONSOLE_IN_ack=0, RX_full=0, RX_data=0.
REQ-032 Reset asserted mid-transfer SHALL discard all FIFO contents and any unread RX byte; a console handshake in progress restarts from RX_IDLE after release.

Structure
REQ-033 Shared package SHALL hold the RX FSM state encoding and the default DEPTH constant.
REQ-034 The FIFO SHALL be a sub-module named console_fifo (DEPTH, 8-bit data, push/pop/full/empty); arbitration and RX FSM stay in console_arbiter.

Verification
REQ-035 WR0 pushes 0x41,0x42 with CONSOLE_OUT_ready=1 -> CONSOLE_OUT shows 0x41 then 0x42, valid first asserted one cycle after first accept.
REQ-036 WR0 and WR1 both valid for 4 cycles with bytes 0x30/0x31, sink ready -> accepted order 0x30,0x31,0x30,0x31.
REQ-037 CONSOLE_OUT_ready=0, WR0 pushes 5 bytes with DEPTH=4 -> 4 accepted, WR0_ready low on 5th until one pop; head stable throughout.
REQ-038 CONSOLE_IN=0x5A, valid high -> RX_data=0x5A, RX_full=1, ack high until valid drops; second byte 0x5B withheld (ack stays 0) until RX_rd pulse.
REQ-039 RESET pulsed low with 3 bytes queued and RX_full=1 -> CONSOLE_OUT_valid=0, RX_full=0 immediately, next push appears normally.
